// File: rtl/rps_pkg.sv
// Shared move/result codes, round-controller states and the counter/beats rules
// for the rock-paper-scissors game.
package rps_pkg;

    localparam logic [1:0] ROCK     = 2'd0;
    localparam logic [1:0] PAPER    = 2'd1;
    localparam logic [1:0] SCISSORS = 2'd2;
    localparam logic [1:0] ILLEGAL  = 2'd3;

    localparam logic [1:0] TIE   = 2'd0;
    localparam logic [1:0] P_WIN = 2'd1;
    localparam logic [1:0] A_WIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        JUDGE     = 2'd1,
        WAIT_PRED = 2'd2,
        DONE      = 2'd3
    } state_t;

    // The move that defeats m.
    function automatic logic [1:0] counter(input logic [1:0] m);
        return (m == SCISSORS) ? ROCK : m + 2'd1;
    endfunction

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return a == counter(b);
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational referee: compares the player's move against the AI's move.
// Also instantiated by the display logic.
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] pmove,
    input  logic [1:0] amove,
    output logic [1:0] result
);

    always_comb begin
        result = A_WIN;
        if (pmove == amove)
            result = TIE;
        else if (beats(pmove, amove))
            result = P_WIN;
    end

endmodule

// File: rtl/rps_round_ctrl.sv
// Round sequencer and referee: commits the AI's counter-move, scores the round
// and hands the {ai,player} combination back to the predictor.
//
//   state     | meaning
//   IDLE      | waiting for a legal player move
//   JUDGE     | round outcome on the outputs; arm the prediction timer
//   WAIT_PRED | count down to the predictor's answer, then capture it
//   DONE      | a side reached WIN_TARGET; only new_match is honoured
module rps_round_ctrl
    import rps_pkg::*;
#(
    parameter int PRED_LAT   = 2,
    parameter int WIN_TARGET = 5,
    parameter int CNT_W      = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       player_move,
    input  logic             move_valid,
    input  logic             new_match,
    input  logic [1:0]       predict_in,
    output logic [3:0]       combination,
    output logic             comb_valid,
    output logic [1:0]       ai_move,
    output logic [1:0]       result,
    output logic             result_valid,
    output logic [CNT_W-1:0] player_score,
    output logic [CNT_W-1:0] ai_score,
    output logic             match_over,
    output logic             busy,
    output logic             illegal
);

    localparam int LAT_W = (PRED_LAT > 2) ? $clog2(PRED_LAT) : 1;
    localparam logic [CNT_W-1:0] TARGET = CNT_W'(WIN_TARGET);

    state_t           state;
    logic [1:0]       pred_reg;
    logic [LAT_W-1:0] lat_cnt;
    logic [1:0]       ai_next;
    logic [1:0]       judge_res;

    assign ai_next = counter(pred_reg);

    // Judged straight from the input so the outcome lands one cycle after move_valid.
    rps_judge u_judge (
        .pmove  (player_move),
        .amove  (ai_next),
        .result (judge_res)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            pred_reg     <= ROCK;
            lat_cnt      <= '0;
            combination  <= '0;
            comb_valid   <= 1'b0;
            ai_move      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            player_score <= '0;
            ai_score     <= '0;
            match_over   <= 1'b0;
            busy         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            comb_valid   <= 1'b0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        if (player_move == ILLEGAL) begin
                            illegal <= 1'b1;
                        end else begin
                            ai_move      <= ai_next;
                            combination  <= {ai_next, player_move};
                            result       <= judge_res;
                            result_valid <= 1'b1;
                            comb_valid   <= 1'b1;
                            if (judge_res == P_WIN && player_score != TARGET)
                                player_score <= player_score + 1'b1;
                            if (judge_res == A_WIN && ai_score != TARGET)
                                ai_score <= ai_score + 1'b1;
                            busy  <= 1'b1;
                            state <= JUDGE;
                        end
                    end
                end
                JUDGE: begin
                    lat_cnt <= LAT_W'(PRED_LAT - 1);
                    state   <= WAIT_PRED;
                end
                WAIT_PRED: begin
                    if (lat_cnt == '0) begin
                        pred_reg <= predict_in;
                        busy     <= 1'b0;
                        if (player_score == TARGET || ai_score == TARGET) begin
                            match_over <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (new_match) begin
                        player_score <= '0;
                        ai_score     <= '0;
                        match_over   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl: a table of scored rounds plus hand-written
// sequences for illegal moves, back-to-back strobes, match end and mid-round reset.
module tb_rps_round_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] player_move;
    logic       move_valid;
    logic       new_match;
    logic [1:0] predict_in;
    logic [3:0] combination;
    logic       comb_valid;
    logic [1:0] ai_move;
    logic [1:0] result;
    logic       result_valid;
    logic [3:0] player_score;
    logic [3:0] ai_score;
    logic       match_over;
    logic       busy;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    rps_round_ctrl #(.PRED_LAT(2), .WIN_TARGET(5), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .player_move  (player_move),
        .move_valid   (move_valid),
        .new_match    (new_match),
        .predict_in   (predict_in),
        .combination  (combination),
        .comb_valid   (comb_valid),
        .ai_move      (ai_move),
        .result       (result),
        .result_valid (result_valid),
        .player_score (player_score),
        .ai_score     (ai_score),
        .match_over   (match_over),
        .busy         (busy),
        .illegal      (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mv;
        logic [1:0] pred;
        logic [1:0] exp_ai;
        logic [1:0] exp_res;
        logic [3:0] exp_comb;
        logic [3:0] exp_ps;
        logic [3:0] exp_as;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    // Presents one move; returns in the cycle after move_valid (the judged cycle).
    task automatic strobe_move(input logic [1:0] mv, input logic [1:0] pr);
        player_move = mv;
        predict_in  = pr;
        move_valid  = 1'b1;
        @(negedge clock);
        move_valid  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_comb"}, combination, 0);
        chk({tag, "_cv"}, comb_valid, 0);
        chk({tag, "_ai"}, ai_move, 0);
        chk({tag, "_res"}, result, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_ps"}, player_score, 0);
        chk({tag, "_as"}, ai_score, 0);
        chk({tag, "_mo"}, match_over, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ill"}, illegal, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; player_move = 2'd0; move_valid = 1'b0;
        new_match = 1'b0; predict_in = 2'd0;

        // mv, pred, ai, result, combination, player score, ai score
        vecs[0] = '{2'd0, 2'd2, 2'd1, 2'd2, 4'b0100, 4'd0, 4'd1};
        vecs[1] = '{2'd1, 2'd1, 2'd0, 2'd1, 4'b0001, 4'd1, 4'd1};
        vecs[2] = '{2'd2, 2'd0, 2'd2, 2'd0, 4'b1010, 4'd1, 4'd1};
        vecs[3] = '{2'd2, 2'd2, 2'd1, 2'd1, 4'b0110, 4'd2, 4'd1};
        vecs[4] = '{2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 4'd2, 4'd1};

        @(negedge clock);
        check_all_zero("reset");
        do_reset();

        for (int i = 0; i < 5; i++) begin
            strobe_move(vecs[i].mv, vecs[i].pred);
            chk($sformatf("v%0d_rv", i), result_valid, 1);
            chk($sformatf("v%0d_cv", i), comb_valid, 1);
            chk($sformatf("v%0d_ai", i), ai_move, vecs[i].exp_ai);
            chk($sformatf("v%0d_res", i), result, vecs[i].exp_res);
            chk($sformatf("v%0d_comb", i), combination, vecs[i].exp_comb);
            chk($sformatf("v%0d_ps", i), player_score, vecs[i].exp_ps);
            chk($sformatf("v%0d_as", i), ai_score, vecs[i].exp_as);
            @(negedge clock);
            chk($sformatf("v%0d_rv_drop", i), result_valid, 0);
            chk($sformatf("v%0d_comb_hold", i), combination, vecs[i].exp_comb);
            wait_idle();
        end

        // Illegal move: pulse only, nothing scored.
        strobe_move(2'd3, 2'd0);
        chk("ill_pulse", illegal, 1);
        chk("ill_rv", result_valid, 0);
        chk("ill_busy", busy, 0);
        chk("ill_ps", player_score, 2);
        chk("ill_as", ai_score, 1);
        @(negedge clock);
        chk("ill_pulse_end", illegal, 0);

        // Back-to-back strobes: second one dropped, busy for t+1..t+3.
        strobe_move(2'd0, 2'd0);
        chk("b2b_rv1", result_valid, 1);
        chk("b2b_busy1", busy, 1);
        player_move = 2'd1; move_valid = 1'b1;
        @(negedge clock);
        move_valid = 1'b0;
        chk("b2b_rv2", result_valid, 0);
        chk("b2b_busy2", busy, 1);
        @(negedge clock);
        chk("b2b_busy3", busy, 1);
        chk("b2b_ps", player_score, 2);
        chk("b2b_as", ai_score, 2);
        @(negedge clock);
        chk("b2b_busy4", busy, 0);
        strobe_move(2'd0, 2'd0);
        chk("b2b_accept", result_valid, 1);
        chk("b2b_as2", ai_score, 3);
        wait_idle();

        // Match: AI wins five straight, last round leaves prediction = paper.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            strobe_move(2'd0, (i == 4) ? 2'd1 : 2'd0);
            chk($sformatf("m%0d_res", i), result, 2);
            wait_idle();
        end
        chk("m_over", match_over, 1);
        chk("m_as", ai_score, 5);
        chk("m_busy", busy, 0);
        strobe_move(2'd1, 2'd0);
        chk("done_drop_rv", result_valid, 0);
        strobe_move(2'd3, 2'd0);
        chk("done_no_ill", illegal, 0);
        chk("done_as_hold", ai_score, 5);
        player_move = 2'd0; move_valid = 1'b1; new_match = 1'b1;
        @(negedge clock);
        move_valid = 1'b0; new_match = 1'b0;
        chk("nm_rv", result_valid, 0);
        chk("nm_as", ai_score, 0);
        chk("nm_over", match_over, 0);
        chk("nm_busy", busy, 0);
        // Retained prediction (paper) -> AI plays scissors, rock wins.
        strobe_move(2'd0, 2'd2);
        chk("nm_ai", ai_move, 2);
        chk("nm_res", result, 1);
        chk("nm_ps", player_score, 1);
        wait_idle();
        new_match = 1'b1;
        @(negedge clock);
        new_match = 1'b0;
        chk("nm_idle_ignored", player_score, 1);

        // Reset in WAIT_PRED clears everything, including the prediction.
        strobe_move(2'd1, 2'd2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("midrst");
        reset = 1'b0;
        strobe_move(2'd0, 2'd0);
        chk("midrst_ai", ai_move, 1);
        chk("midrst_as", ai_score, 1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
